// File: rtl/sb_pkg.sv
// Shared constants for the store buffer: default depth, FSM encoding,
// pointer sizing and the word span used by the partial-overlap compare.
package sb_pkg;

  localparam int SB_DEPTH   = 4;
  localparam int WORD_BYTES = 4;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_FLUSHING = 1'b1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sb_addr_match.sv
// Load lookup against buffered stores: exact and partial-overlap detection,
// with the youngest exact match (closest to tail) winning the index select.
module sb_addr_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = 32,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0][AW-1:0] addr,
  input  logic [PW-1:0]            head,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     hit,
  output logic                     conflict,
  output logic [PW-1:0]            index
);

  localparam logic [AW-1:0] NEAR = AW'(WORD_BYTES);

  logic [PW-1:0] slot;
  logic [AW-1:0] up;
  logic [AW-1:0] dn;
  logic          exact_any;

  // Walk oldest to youngest so a later (younger) exact match overrides the index.
  always_comb begin
    exact_any = 1'b0;
    conflict  = 1'b0;
    index     = '0;
    slot      = '0;
    up        = '0;
    dn        = '0;
    for (int age = 0; age < DEPTH; age++) begin
      slot = head + PW'(age);
      up   = addr[slot] - ld_addr;
      dn   = ld_addr - addr[slot];
      if (ld_valid && valid[slot]) begin
        if (addr[slot] == ld_addr) begin
          exact_any = 1'b1;
          index     = slot;
        end else if (up < NEAR || dn < NEAR) begin
          conflict = 1'b1;
        end
      end
    end
    hit = exact_any && !conflict;
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between MEM stage and data memory: single-cycle store
// accept, in-order drain on mem_grant, load forwarding and flush handshake.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic [DW-1:0] ld_data,
  output logic          ld_conflict,
  input  logic          mem_grant,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic          flush_req,
  output logic          flush_done,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [0:0]               state;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [DEPTH-1:0]         vld;
  logic [DEPTH-1:0][AW-1:0] e_addr;
  logic [DEPTH-1:0][DW-1:0] e_data;
  logic [PW-1:0]            hit_idx;
  logic                     enq;
  logic                     deq;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign st_ready  = !full && (state == ST_IDLE);
  assign enq       = st_valid && st_ready;
  assign mem_write = !empty && mem_grant;
  assign deq       = mem_write;
  assign mem_addr  = e_addr[head];
  assign mem_din   = e_data[head];

  sb_addr_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .valid    (vld),
    .addr     (e_addr),
    .head     (head),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .hit      (ld_hit),
    .conflict (ld_conflict),
    .index    (hit_idx)
  );

  assign ld_data = ld_hit ? e_data[hit_idx] : '0;

  // Payload is only meaningful under its valid bit, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (enq) begin
      e_addr[tail] <= st_addr;
      e_data[tail] <= st_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      vld        <= '0;
      state      <= ST_IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (enq) begin
        vld[tail] <= 1'b1;
        tail      <= tail + 1'b1;
      end
      if (deq) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      count <= count + CW'(enq) - CW'(deq);
      case (state)
        ST_IDLE: begin
          // A store accepted alongside the request still has to drain first.
          if (flush_req) begin
            if (empty && !enq) flush_done <= 1'b1;
            else               state      <= ST_FLUSHING;
          end
        end
        ST_FLUSHING: begin
          if (empty) begin
            state      <= ST_IDLE;
            flush_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a big-endian 128-byte memory model
// that commits on the falling edge whenever mem_write is high.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_conflict;
  logic        mem_grant;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        flush_req;
  logic        flush_done;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  logic [7:0] mem [0:127];
  int errs   = 0;
  int checks = 0;

  store_buffer dut (
    .CLK         (clk),
    .RST         (rst),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_ready    (st_ready),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_hit      (ld_hit),
    .ld_data     (ld_data),
    .ld_conflict (ld_conflict),
    .mem_grant   (mem_grant),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write) begin
      for (int k = 0; k < 4; k++)
        mem[7'(mem_addr + 32'(k))] <= mem_din[31-8*k -: 8];
    end
  end

  function automatic logic [31:0] rd(input logic [6:0] a);
    return {mem[a], mem[a + 7'd1], mem[a + 7'd2], mem[a + 7'd3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flush sequence tables, one entry per cycle after the flush_req pulse.
  logic [2:0]  exp_cnt [8] = '{3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
  logic        exp_mw  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        exp_rdy [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        exp_fd  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] exp_ma  [8] = '{32'h20, 32'h0, 32'h30, 32'h0, 32'h40, 32'h0, 32'h0, 32'h0};

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_grant = 1'b0; flush_req = 1'b0;
    step(); step();

    // Reset state, with grant high to show an empty buffer never writes
    mem_grant = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    ld_valid = 1'b1; ld_addr = 32'h0;
    #1;
    chk("rst_ld_hit", 32'(ld_hit), 32'd0);
    chk("rst_ld_conflict", 32'(ld_conflict), 32'd0);
    ld_valid = 1'b0; mem_grant = 1'b0; rst = 1'b0;
    step();

    // Fill to full with grant low
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 32'(i * 4); st_data = 32'h11111111 * 32'(i + 1);
      #1;
      chk("fill_st_ready", 32'(st_ready), 32'd1);
      step();
    end
    st_addr = 32'h40; st_data = 32'h55555555;
    #1;
    chk("full_flag", 32'(full), 32'd1);
    chk("full_st_ready", 32'(st_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    step();
    st_valid = 1'b0;
    #1;
    chk("fifth_rejected_count", 32'(count), 32'd4);

    // In-order drain
    for (int i = 0; i < 4; i++) begin
      mem_grant = 1'b1;
      #1;
      chk("drain_mem_write", 32'(mem_write), 32'd1);
      chk("drain_mem_addr", mem_addr, 32'(i * 4));
      chk("drain_mem_din", mem_din, 32'h11111111 * 32'(i + 1));
      step();
    end
    mem_grant = 1'b0;
    #1;
    chk("drained_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++)
      chk("mem_readback", rd(7'(i * 4)), 32'h11111111 * 32'(i + 1));

    // Youngest-match forwarding; same-cycle enqueue not visible
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hAAAAAAAA;
    ld_valid = 1'b1; ld_addr = 32'h10;
    #1;
    chk("enq_not_visible_hit", 32'(ld_hit), 32'd0);
    step();
    st_data = 32'hBBBBBBBB;
    #1;
    chk("older_fwd_data", ld_data, 32'hAAAAAAAA);
    step();
    st_valid = 1'b0;
    #1;
    chk("young_fwd_hit", 32'(ld_hit), 32'd1);
    chk("young_fwd_data", ld_data, 32'hBBBBBBBB);
    chk("young_fwd_conflict", 32'(ld_conflict), 32'd0);
    ld_addr = 32'h14;
    #1;
    chk("miss_hit", 32'(ld_hit), 32'd0);
    chk("miss_data", ld_data, 32'd0);
    chk("miss_conflict", 32'(ld_conflict), 32'd0);
    ld_valid = 1'b0; ld_addr = 32'h10;
    #1;
    chk("ld_valid_low_hit", 32'(ld_hit), 32'd0);

    // Partial overlap
    st_valid = 1'b1; st_addr = 32'h20; st_data = 32'h20202020;
    step();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h22;
    #1;
    chk("ovl_conflict", 32'(ld_conflict), 32'd1);
    chk("ovl_hit", 32'(ld_hit), 32'd0);
    chk("ovl_data", ld_data, 32'd0);
    ld_addr = 32'h24;
    #1;
    chk("adj_conflict", 32'(ld_conflict), 32'd0);
    chk("adj_hit", 32'(ld_hit), 32'd0);
    ld_addr = 32'h0E;
    #1;
    chk("below_conflict", 32'(ld_conflict), 32'd1);
    ld_valid = 1'b0;

    // Full with drain and store in the same cycle, then tail wrap
    st_valid = 1'b1; st_addr = 32'h30; st_data = 32'hCCCCCCCC;
    step();
    st_addr = 32'h40; st_data = 32'hDDDDDDDD; mem_grant = 1'b1;
    #1;
    chk("fd_count", 32'(count), 32'd4);
    chk("fd_st_ready", 32'(st_ready), 32'd0);
    chk("fd_mem_addr", mem_addr, 32'h10);
    chk("fd_mem_din", mem_din, 32'hAAAAAAAA);
    step();
    #1;
    chk("fd_after_count", 32'(count), 32'd3);
    chk("fd_after_st_ready", 32'(st_ready), 32'd1);
    chk("fd_after_mem_din", mem_din, 32'hBBBBBBBB);
    step();
    st_valid = 1'b0; mem_grant = 1'b0;
    #1;
    chk("wrap_count", 32'(count), 32'd3);
    ld_valid = 1'b1; ld_addr = 32'h40;
    #1;
    chk("wrap_fwd_hit", 32'(ld_hit), 32'd1);
    chk("wrap_fwd_data", ld_data, 32'hDDDDDDDD);
    ld_addr = 32'h10;
    #1;
    chk("drained_no_hit", 32'(ld_hit), 32'd0);
    ld_valid = 1'b0;

    // Flush with alternating grant and a store held pending
    flush_req = 1'b1;
    #1;
    chk("flush_req_cycle_ready", 32'(st_ready), 32'd1);
    step();
    flush_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mem_grant = (c % 2 == 0);
      st_valid  = (c < 6);
      st_addr   = 32'h60; st_data = 32'h66666666;
      #1;
      chk("flush_count", 32'(count), 32'(exp_cnt[c]));
      chk("flush_st_ready", 32'(st_ready), 32'(exp_rdy[c]));
      chk("flush_done", 32'(flush_done), 32'(exp_fd[c]));
      chk("flush_mem_write", 32'(mem_write), 32'(exp_mw[c]));
      if (exp_mw[c]) chk("flush_mem_addr", mem_addr, exp_ma[c]);
      step();
    end
    st_valid = 1'b0; mem_grant = 1'b0;
    chk("mem_0x20", rd(7'h20), 32'h20202020);
    chk("mem_0x40", rd(7'h40), 32'hDDDDDDDD);

    // Flush on empty buffer
    flush_req = 1'b1;
    #1;
    chk("eflush_same_cycle", 32'(flush_done), 32'd0);
    step();
    flush_req = 1'b0;
    #1;
    chk("eflush_done", 32'(flush_done), 32'd1);
    chk("eflush_ready", 32'(st_ready), 32'd1);
    step();
    chk("eflush_pulse_end", 32'(flush_done), 32'd0);

    // Reset in the middle of a flush
    st_valid = 1'b1; st_addr = 32'h50; st_data = 32'h50505050;
    step();
    st_addr = 32'h54; st_data = 32'h54545454;
    step();
    st_valid = 1'b0; flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    #1;
    chk("mf_st_ready", 32'(st_ready), 32'd0);
    chk("mf_count", 32'(count), 32'd2);
    mem_grant = 1'b1; rst = 1'b1;
    #1;
    chk("mf_rst_mem_write", 32'(mem_write), 32'd1);
    chk("mf_rst_mem_addr", mem_addr, 32'h50);
    step();
    rst = 1'b0;
    #1;
    chk("mf_after_count", 32'(count), 32'd0);
    chk("mf_after_ready", 32'(st_ready), 32'd1);
    chk("mf_after_mem_write", 32'(mem_write), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mf_no_flush_done", 32'(flush_done), 32'd0);
    end
    mem_grant = 1'b0;
    chk("mf_mem_0x50", rd(7'h50), 32'h50505050);
    chk("mf_mem_0x54", rd(7'h54), 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
